// File: rtl/insn_mem_if.sv
// Bus bundle for insn_mem: write port, read port and clear-sweep status.
interface insn_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] wraddress;
  logic              wren;
  logic [ADDR_W-1:0] rdaddress;
  logic [DATA_W-1:0] q;
  logic              init_busy;

  modport master (output data, wraddress, wren, rdaddress, input q, init_busy);
  modport slave  (input data, wraddress, wren, rdaddress, output q, init_busy);
endinterface

// File: rtl/insn_mem.sv
// Simple dual-port RAM (1 write, 1 read) with a post-reset zeroing sweep.
// The read address is registered; q is the combinational word at that address.
// A write that lands on the sampled read address at the same edge returns the
// pre-write word for that one cycle, so a small capture register holds it.
module insn_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic        clock,
  input  logic        reset,
  insn_mem_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              rdw_q, rdw_d;
  logic [DATA_W-1:0] rdw_data_q, rdw_data_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // Next-state: sweep writes zeros while busy, else the user write port is live.
  always_comb begin
    rd_addr_d  = bus.rdaddress;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    rdw_d      = 1'b0;
    rdw_data_d = rdw_data_q;
    mem_we     = 1'b0;
    mem_wa     = bus.wraddress;
    mem_wd     = bus.data;
    if (busy_q) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
      cnt_d  = cnt_q + ADDR_W'(1);
      if (cnt_q == {ADDR_W{1'b1}}) busy_d = 1'b0;
    end else if (bus.wren) begin
      mem_we = 1'b1;
      if (bus.wraddress == bus.rdaddress) begin
        rdw_d      = 1'b1;
        rdw_data_d = mem[bus.rdaddress];
      end
    end
  end

  // Control registers; reset restarts the sweep from address 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
      rdw_q     <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      rdw_q     <= rdw_d;
    end
  end

  // Old-word capture for read-during-write; qualified by rdw_q so no reset needed.
  always_ff @(posedge clock) begin
    rdw_data_q <= rdw_data_d;
  end

  // Storage array; no write happens on a reset edge.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[mem_wa] <= mem_wd;
  end

  assign bus.init_busy = busy_q;
  assign bus.q = busy_q ? '0 : (rdw_q ? rdw_data_q : mem[rd_addr_q]);

endmodule

// File: tb/tb_insn_mem.sv
// Directed bench for insn_mem: default 256x32 instance plus a 16-deep
// instance with tied read/write addresses.
module tb_insn_mem;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   n;

  always #5 clock = ~clock;

  insn_mem_if #(.ADDR_W(8), .DATA_W(32)) b ();
  insn_mem_if #(.ADDR_W(4), .DATA_W(32)) m ();

  assign m.rdaddress = m.wraddress;

  insn_mem #(.ADDR_W(8), .DATA_W(32)) dut (.clock(clock), .reset(reset), .bus(b));
  insn_mem #(.ADDR_W(4), .DATA_W(32)) dut_mlab (.clock(clock), .reset(reset), .bus(m));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Count cycles with init_busy high, starting from the current sample.
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 400 && b.init_busy === 1'b1; i++) begin
      cnt++;
      tick();
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    b.wraddress = a; b.data = d; b.wren = 1'b1;
    tick();
    b.wren = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    b.rdaddress = a;
    tick();
    chk(tag, b.q, exp);
  endtask

  initial begin
    reset = 1'b1;
    b.data = '0; b.wraddress = '0; b.wren = 1'b0; b.rdaddress = '0;
    m.data = '0; m.wraddress = '0; m.wren = 1'b0;
    tick();
    chk("rst_busy", 32'(b.init_busy), 32'd1);
    chk("rst_q", b.q, 32'h0);
    chk("rst_mlab_busy", 32'(m.init_busy), 32'd1);
    reset = 1'b0;

    // Writes attempted during the sweep must be dropped; q held at 0.
    b.wren = 1'b1; b.wraddress = 8'h33; b.data = 32'h12345678; b.rdaddress = 8'h33;
    tick(); tick();
    chk("busy_q_forced", b.q, 32'h0);
    count_busy(n);
    chk("sweep_len", 32'(n + 2), 32'd256);
    b.wren = 1'b0;
    chk("mlab_sweep_done", 32'(m.init_busy), 32'd0);

    rd("sweep_00", 8'h00, 32'h0);
    rd("sweep_7f", 8'h7F, 32'h0);
    rd("sweep_ff", 8'hFF, 32'h0);
    rd("sweep_wren_ignored", 8'h33, 32'h0);

    // Write/read latency.
    b.rdaddress = 8'h00;
    wr(8'h10, 32'hDEADBEEF);
    b.rdaddress = 8'h10;
    chk("lat_before_edge", b.q, 32'h0);
    tick();
    chk("lat_after_edge", b.q, 32'hDEADBEEF);

    // Read-during-write returns old word, then new word.
    wr(8'h20, 32'h11111111);
    b.rdaddress = 8'h20;
    wr(8'h20, 32'h22222222);
    chk("rdw_old", b.q, 32'h11111111);
    tick();
    chk("rdw_new", b.q, 32'h22222222);

    // Write gating and isolation.
    b.wren = 1'b0; b.wraddress = 8'h05; b.data = 32'hFFFFFFFF;
    tick();
    rd("gate_05", 8'h05, 32'h0);
    rd("iso_10", 8'h10, 32'hDEADBEEF);
    rd("iso_11", 8'h11, 32'h0);
    rd("iso_1f", 8'h1F, 32'h0);

    // Reset mid-sweep restarts from address 0.
    wr(8'hF0, 32'hAAAA5555);
    rd("pre_mid_f0", 8'hF0, 32'hAAAA5555);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_busy_100", 32'(b.init_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_restart_busy", 32'(b.init_busy), 32'd1);
    count_busy(n);
    chk("mid_sweep_len", 32'(n), 32'd256);
    rd("mid_f0_cleared", 8'hF0, 32'h0);
    rd("mid_10_cleared", 8'h10, 32'h0);

    // 16-deep tied-address instance.
    m.wraddress = 4'h3; m.data = 32'h3; m.wren = 1'b1;
    tick();
    m.wren = 1'b0;
    tick();
    chk("mlab_q3", m.q, 32'h3);
    m.wraddress = 4'h4;
    tick();
    chk("mlab_q4", m.q, 32'h0);
    m.wraddress = 4'h3;
    tick();
    chk("mlab_q3_again", m.q, 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
